replay_buffer_demux_n: RTL and testbench
========================================

REPLAY_BUFFER_DEMUX_N -- requirements
Module: replay_buffer_demux_n

Interface
REQ-001 SHALL have parameter Q, default 2: number of muxed spike wires.
REQ-002 SHALL have parameter N_NET, default 2: networks time-multiplexed per wire; legal range 2..8.
REQ-003 SHALL have parameter GAMMA_CYCLE_LENGTH (G), default 18: cycles per gamma cycle; G mod N_NET = 0; slot length S = G/N_NET.
REQ-004 SHALL have parameter MODE, default RB_STRETCH: RB_STRETCH repeats each sample N_NET times; RB_PULSE writes the sample to the first sub-entry only, zeros to the rest.
REQ-005 SHALL have port clk, input, 1: sole clock, all state rising-edge.
REQ-006 SHALL have port rstb, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port gamma_start, input, 1: single-cycle pulse marking input time 0 of a gamma cycle.
REQ-008 SHALL have port muxed_spikes, input, Q: network k drives slot k (input times k*S..k*S+S-1).
REQ-009 SHALL have port demuxed_spikes, output, Q x N_NET: replayed per-network spikes, registered.
REQ-010 SHALL have port out_valid, output, 1: current replay comes from a complete gamma cycle.
REQ-011 SHALL have port early_err, output, 1: one-cycle pulse on premature gamma_start.

Function
REQ-012 SHALL keep two banks per wire per network (ping-pong), each G bits; one bank written while the other is read.
REQ-013 SHALL hold a write counter t (width clog2(G)): t=0 on the gamma_start cycle, t+1 each cycle after, saturating at G-1.
REQ-014 SHALL, at input time t, write muxed_spikes[i] into the write bank of network k=t/S at entries j*N_NET..j*N_NET+N_NET-1, with j=t mod S (per MODE).
REQ-015 SHALL implement FSM IDLE, RUN, WAIT: IDLE->RUN on gamma_start; RUN->WAIT when t=G-1 with no gamma_start next cycle; WAIT->RUN on gamma_start; any state->RUN on gamma_start.
REQ-016 SHALL swap write/read banks on every gamma_start cycle, including the first.
REQ-017 SHALL present read-bank entry r on demuxed_spikes[i][k] at cycle c+1+r, where c is the gamma_start cycle, r=0..G-1 (latency 1).
REQ-018 SHALL mark a bank complete only when all G input times were written before the swap; out_valid SHALL be high for the G output cycles replaying a complete bank.
REQ-019 SHALL force demuxed_spikes to 0 whenever out_valid is low, in IDLE, and in WAIT.
REQ-020 SHALL, on gamma_start while in RUN with t<G-1, pulse early_err at c+1, swap banks, and mark the partially written bank incomplete.
REQ-021 SHALL treat gamma_start exactly at t=G-1+1 (back-to-back gammas) as the normal case: no early_err, no idle gap.
REQ-022 SHALL stop writing in WAIT and IDLE; late gamma_start (after WAIT) is not an error.

Reset
REQ-023 SHALL, on rstb low, asynchronously clear: FSM to IDLE, t=0, bank select 0, both complete flags, demuxed_spikes=0, out_valid=0, early_err=0.
REQ-024 SHALL not require bank contents to reset; complete flags gate all output.
REQ-025 SHALL, on reset mid-gamma, discard all buffered data: first gamma_start after reset produces no valid replay.

Structure
REQ-026 SHALL place the MODE enum (RB_STRETCH, RB_PULSE) and FSM state typedef in package rb_demux_pkg.
REQ-027 SHALL use one sub-module rb_demux_lane per wire: holds 2 x N_NET x G bits, write/read indexing; FSM, counter, complete flags and bank select live once in the top.

Verification
REQ-028 Q=2,N_NET=2,G=18, wire0 = 1 at t=3 only, back-to-back gammas -> next gamma demuxed_spikes[0][0]=1 at c+1+6 and c+1+7, all else 0, out_valid high 18 cycles.
REQ-029 Same, MODE=RB_PULSE, wire1 = 1 at t=9 -> demuxed_spikes[1][1]=1 only at c+1+0.
REQ-030 gamma_start at t=10 -> early_err pulse 1 cycle, following replay out_valid=0, outputs 0; next complete gamma replays normally.
REQ-031 No gamma_start after t=17 for 5 cycles -> WAIT, outputs 0, no early_err; gamma_start then -> replay of the completed gamma with out_valid=1.
REQ-032 rstb low at t=8 mid-replay -> all outputs 0 immediately; first post-reset gamma out_valid=0.
REQ-033 N_NET=3,G=18 (S=6), network 2 spike at t=13 -> demuxed_spikes[i][2]=1 at c+1+3..c+1+5.

Source files
------------

// File: rtl/rb_demux_pkg.sv
// ==========================================================================
// Module   : rb_demux_pkg -- shared types for the replay buffer demux
// Revision : 1.0
// ==========================================================================
`default_nettype none

package rb_demux_pkg;

    typedef enum logic {
        RB_STRETCH = 1'b0,
        RB_PULSE   = 1'b1
    } rb_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } rb_state_e;

endpackage

`default_nettype wire

// File: rtl/rb_demux_lane.sv
// ==========================================================================
// Module   : rb_demux_lane -- ping-pong sample storage for one muxed wire
// Revision : 1.0
// ==========================================================================
`default_nettype none

module rb_demux_lane
    import rb_demux_pkg::*;
#(
    parameter int       N_NET = 2,
    parameter int       G     = 18,
    parameter rb_mode_e MODE  = RB_STRETCH
) (
    input  logic                   clk,
    input  logic                   wr_en_i,
    input  logic                   wr_bank_i,
    input  logic                   rd_bank_i,
    input  logic [$clog2(G)-1:0]   t_i,
    input  logic                   spike_i,
    output logic [N_NET-1:0]       rd_data_o
);

    localparam int c_S  = G / N_NET;
    localparam int c_TW = $clog2(G);
    localparam int c_KW = $clog2(N_NET);

    // Contents are never reset: the top's complete flags gate every read.
    logic [G-1:0]      mem_q [2][N_NET];
    logic [c_TW-1:0]   slot;
    logic [c_TW-1:0]   sub;
    logic [c_TW-1:0]   base;
    logic [c_KW-1:0]   net;

    always_comb begin
        slot = t_i / c_TW'(c_S);
        sub  = t_i % c_TW'(c_S);
        base = sub * c_TW'(N_NET);
        net  = c_KW'(slot);
    end

    // Sample at slot offset j expands to N_NET consecutive output entries.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int n = 0; n < N_NET; n++) begin
                mem_q[wr_bank_i][net][base + c_TW'(n)] <=
                    (MODE == RB_STRETCH || n == 0) ? spike_i : 1'b0;
            end
        end
    end

    for (genvar k = 0; k < N_NET; k++) begin : g_rd
        assign rd_data_o[k] = mem_q[rd_bank_i][k][t_i];
    end

endmodule

`default_nettype wire

// File: rtl/replay_buffer_demux_n.sv
// ==========================================================================
// Module   : replay_buffer_demux_n -- records one gamma cycle of muxed spikes
//            and replays it per network during the next gamma cycle
// Revision : 1.0
// ==========================================================================
`default_nettype none

module replay_buffer_demux_n
    import rb_demux_pkg::*;
#(
    parameter int       Q                  = 2,
    parameter int       N_NET              = 2,
    parameter int       GAMMA_CYCLE_LENGTH = 18,
    parameter rb_mode_e MODE               = RB_STRETCH
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        gamma_start,
    input  logic [Q-1:0]                muxed_spikes,
    output logic [Q-1:0][N_NET-1:0]     demuxed_spikes,
    output logic                        out_valid,
    output logic                        early_err
);

    localparam int              c_G      = GAMMA_CYCLE_LENGTH;
    localparam int              c_TW     = $clog2(c_G);
    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(c_G - 1);
    localparam logic [c_TW-1:0] c_T_ONE  = c_TW'(1);

    rb_state_e               state_q, state_d;
    logic [c_TW-1:0]         t_q, t_d, t_cur;
    logic                    done_q, done_d;
    logic                    sel_q, sel_d;
    logic [1:0]              cmpl_q, cmpl_d;
    logic [Q-1:0][N_NET-1:0] demux_q, demux_d, rd_data;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    active, wr_bank, rd_bank;

    // done_q marks that time G-1 has been consumed, so the saturated
    // counter cannot be mistaken for a fresh G-1 on the following cycle.
    always_comb begin
        t_cur   = gamma_start ? '0 : t_q;
        active  = gamma_start || (state_q == ST_RUN && !done_q);
        wr_bank = gamma_start ? ~sel_q : sel_q;
        rd_bank = ~wr_bank;
        sel_d   = wr_bank;

        state_d = state_q;
        if (gamma_start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (done_q) state_d = ST_WAIT;
                ST_IDLE: state_d = ST_IDLE;
                ST_WAIT: state_d = ST_WAIT;
                default: state_d = ST_IDLE;
            endcase
        end

        t_d = t_q;
        if (gamma_start) begin
            t_d = c_T_ONE;
        end else if (state_q == ST_RUN && t_q != c_T_LAST) begin
            t_d = t_q + c_T_ONE;
        end

        done_d = gamma_start ? 1'b0 : done_q;
        cmpl_d = cmpl_q;
        if (gamma_start) begin
            cmpl_d[wr_bank] = 1'b0;
        end
        if (active && t_cur == c_T_LAST) begin
            done_d          = 1'b1;
            cmpl_d[wr_bank] = 1'b1;
        end

        err_d   = gamma_start && state_q == ST_RUN && !done_q;
        valid_d = active && cmpl_q[rd_bank];
        demux_d = valid_d ? rd_data : '0;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            done_q  <= 1'b0;
            sel_q   <= 1'b0;
            cmpl_q  <= '0;
            demux_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
            cmpl_q  <= cmpl_d;
            demux_q <= demux_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    for (genvar i = 0; i < Q; i++) begin : g_lane
        rb_demux_lane #(
            .N_NET (N_NET),
            .G     (c_G),
            .MODE  (MODE)
        ) u_lane (
            .clk       (clk),
            .wr_en_i   (active),
            .wr_bank_i (wr_bank),
            .rd_bank_i (rd_bank),
            .t_i       (t_cur),
            .spike_i   (muxed_spikes[i]),
            .rd_data_o (rd_data[i])
        );
    end

    assign demuxed_spikes = demux_q;
    assign out_valid      = valid_q;
    assign early_err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_replay_buffer_demux_n.sv
// ==========================================================================
// Module   : tb_replay_buffer_demux_n -- three configurations driven from one
//            stimulus stream and compared against a gamma-level replay model
// Revision : 1.0
// ==========================================================================
`default_nettype none

module tb_replay_buffer_demux_n;
    import rb_demux_pkg::*;

    localparam int G = 18;

    logic            clk;
    logic            rstb;
    logic            gamma_start;
    logic [1:0]      muxed_spikes;
    logic [1:0][1:0] dm_s, dm_p;
    logic [1:0][2:0] dm_3;
    logic            ov_s, ov_p, ov_3;
    logic            ee_s, ee_p, ee_3;

    replay_buffer_demux_n #(.Q(2), .N_NET(2), .GAMMA_CYCLE_LENGTH(G), .MODE(RB_STRETCH)) dut_s (
        .clk(clk), .rstb(rstb), .gamma_start(gamma_start), .muxed_spikes(muxed_spikes),
        .demuxed_spikes(dm_s), .out_valid(ov_s), .early_err(ee_s));

    replay_buffer_demux_n #(.Q(2), .N_NET(2), .GAMMA_CYCLE_LENGTH(G), .MODE(RB_PULSE)) dut_p (
        .clk(clk), .rstb(rstb), .gamma_start(gamma_start), .muxed_spikes(muxed_spikes),
        .demuxed_spikes(dm_p), .out_valid(ov_p), .early_err(ee_p));

    replay_buffer_demux_n #(.Q(2), .N_NET(3), .GAMMA_CYCLE_LENGTH(G), .MODE(RB_STRETCH)) dut_3 (
        .clk(clk), .rstb(rstb), .gamma_start(gamma_start), .muxed_spikes(muxed_spikes),
        .demuxed_spikes(dm_3), .out_valid(ov_3), .early_err(ee_3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: samples of the gamma in progress, and the snapshot being replayed.
    logic [1:0] cur_buf [G];
    logic [1:0] rep_buf [G];
    int         cur_cnt;
    int         since;
    bit         seen;
    bit         rep_ok;
    logic [5:0] ex_s, ex_p, ex_3;
    logic       ex_v, ex_e;

    // Output entry r of network k holds sample time k*S + r/N; pulse mode
    // keeps only the first of the N copies.
    function automatic logic [5:0] replay_word(int n_net, bit pulse, int r);
        logic [5:0] w;
        int         s;
        w = '0;
        s = G / n_net;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < n_net; k++) begin
                logic [1:0] smp;
                logic       v;
                smp = rep_buf[5'(k * s + r / n_net)];
                v   = smp[i] & (!pulse || (r % n_net) == 0);
                w   = w | (6'(v) << (i * n_net + k));
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        seen    = 1'b0;
        rep_ok  = 1'b0;
        cur_cnt = 0;
        since   = 0;
        ex_s = '0; ex_p = '0; ex_3 = '0; ex_v = 1'b0; ex_e = 1'b0;
    endtask

    task automatic model_step(input logic gs, input logic [1:0] sp);
        bit early;
        early = gs && seen && since < G;
        if (gs) begin
            rep_buf = cur_buf;
            rep_ok  = (cur_cnt == G);
            cur_cnt = 0;
            since   = 0;
            seen    = 1'b1;
        end
        if (seen && since < G) begin
            cur_buf[5'(since)] = sp;
            cur_cnt++;
            ex_v = rep_ok;
            ex_s = rep_ok ? replay_word(2, 1'b0, since) : 6'd0;
            ex_p = rep_ok ? replay_word(2, 1'b1, since) : 6'd0;
            ex_3 = rep_ok ? replay_word(3, 1'b0, since) : 6'd0;
        end else begin
            ex_v = 1'b0;
            ex_s = '0; ex_p = '0; ex_3 = '0;
        end
        ex_e = early;
        if (since < 100000) since++;
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("stretch_demux", {2'b00, dm_s}, ex_s);
        chk("stretch_valid", {5'd0, ov_s},  {5'd0, ex_v});
        chk("stretch_err",   {5'd0, ee_s},  {5'd0, ex_e});
        chk("pulse_demux",   {2'b00, dm_p}, ex_p);
        chk("pulse_valid",   {5'd0, ov_p},  {5'd0, ex_v});
        chk("pulse_err",     {5'd0, ee_p},  {5'd0, ex_e});
        chk("n3_demux",      dm_3,          ex_3);
        chk("n3_valid",      {5'd0, ov_3},  {5'd0, ex_v});
        chk("n3_err",        {5'd0, ee_3},  {5'd0, ex_e});
    endtask

    task automatic step(input logic gs, input logic [1:0] sp);
        gamma_start  = gs;
        muxed_spikes = sp;
        model_step(gs, sp);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // kind 0: random spikes, 1: directed pattern, 2: silent
    task automatic gamma(input int len, input int kind);
        logic [1:0] sp;
        for (int t = 0; t < len; t++) begin
            case (kind)
                1:       sp = {logic'(t == 9 || t == 13), logic'(t == 3 || t == 13)};
                2:       sp = 2'b00;
                default: sp = 2'($urandom_range(0, 3));
            endcase
            step(logic'(t == 0), sp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb         = 1'b0;
        gamma_start  = 1'b0;
        muxed_spikes = 2'b00;
        model_reset();
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);
        rstb = 1'b1;
        step(1'b0, 2'b11);
        step(1'b0, 2'b00);

        // Directed pattern recorded, then replayed back-to-back.
        gamma(G, 1);
        gamma(G, 2);
        gamma(G, 0);

        // Premature gamma_start at t=10, then recovery.
        gamma(10, 0);
        gamma(G, 0);
        gamma(G, 0);

        // Five idle cycles after t=17, then a late start.
        gamma(G + 5, 0);
        gamma(G, 0);

        // Reset in the middle of a replay.
        gamma(9, 0);
        rstb = 1'b0;
        model_reset();
        #1;
        check_all();
        step(1'b0, 2'b01);
        rstb = 1'b1;
        gamma(G, 0);
        gamma(G, 0);

        // Random gamma lengths: short, exact and late starts.
        repeat (8) gamma(int'($urandom_range(8, 24)), 0);
        gamma(G, 0);
        gamma(G, 2);
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
